// File: rtl/axi_wr_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi_wr_slave
// Brief    : AXI4 write-channel responder. Takes one burst at a time on AW,
//            consumes its W beats onto a byte-strobed local write port and
//            returns a single B response per burst.
//            Optional feature macro: WR_SLV_LAST_CHECK_EN (checks wlast
//            against the beat count and flags SLVERR on mismatch).
// Revision : 1.0 - initial release
// ============================================================================
module axi_wr_slave #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512,
  parameter int ID_W   = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                wvalid,
  output logic                wready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  output logic                bvalid,
  input  logic                bready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ready
);

  localparam logic [ADDR_W-1:0] c_one = ADDR_W'(1);
  localparam logic [1:0] c_burst_fixed = 2'b00;
  localparam logic [1:0] c_burst_incr  = 2'b01;
  localparam logic [1:0] c_burst_wrap  = 2'b10;
  localparam logic [1:0] c_resp_okay   = 2'b00;
  localparam logic [1:0] c_resp_slverr = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q;
  logic                awready_q;
  logic                bvalid_q;
  logic [ID_W-1:0]     bid_q;
  logic [1:0]          bresp_q;
  logic [ID_W-1:0]     id_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   addr_d;
  logic [7:0]          len_q;
  logic [2:0]          size_q;
  logic [1:0]          burst_q;
  logic [7:0]          cnt_q;
  logic                err_q;

  logic                w_beat;
  logic                w_last_beat;
  logic                w_last_err;
  logic                w_aw_err;
  logic [ADDR_W-1:0]   w_aw_size;
  logic [ADDR_W-1:0]   w_size;
  logic [ADDR_W-1:0]   w_wrap_mask;
  logic [ADDR_W-1:0]   w_wrap_lower;
  logic [ADDR_W-1:0]   w_inc;

  // A beat is a W handshake while the burst is in its data phase
  assign w_beat      = (state_q == S_DATA) && wvalid && mem_ready;
  assign w_last_beat = (cnt_q == len_q);

`ifdef WR_SLV_LAST_CHECK_EN
  // wlast must appear exactly on the final counted beat
  assign w_last_err = w_beat && (wlast != w_last_beat);
`else
  // wlast carries no meaning here; the burst ends on beat count alone
  logic w_unused_wlast;
  assign w_unused_wlast = wlast;
  assign w_last_err     = 1'b0;
`endif

  // AW-time error decode: reserved burst, oversize beat, illegal WRAP shape
  assign w_aw_size = c_one << awsize;
  assign w_aw_err  = (awburst == 2'b11) || (awsize > 3'd6) ||
                     ((awburst == c_burst_wrap) &&
                      (!((awlen == 8'd1) || (awlen == 8'd3) ||
                         (awlen == 8'd7) || (awlen == 8'd15)) ||
                       ((awaddr & (w_aw_size - c_one)) != '0)));

  // Wrap window size minus one: (len+1)*size-1 == (len<<s) | (size-1)
  assign w_size       = c_one << size_q;
  assign w_wrap_mask  = (ADDR_W'(len_q) << size_q) | (w_size - c_one);
  assign w_wrap_lower = addr_q & ~w_wrap_mask;
  assign w_inc        = addr_q + w_size;

  // Address of the beat following the current one
  always_comb begin
    addr_d = addr_q;
    case (burst_q)
      c_burst_fixed: addr_d = addr_q;
      c_burst_incr:  addr_d = (addr_q & ~(w_size - c_one)) + w_size;
      c_burst_wrap: begin
        if (w_inc == (w_wrap_lower + w_wrap_mask + c_one)) begin
          addr_d = w_wrap_lower;
        end else begin
          addr_d = w_inc;
        end
      end
      default:       addr_d = addr_q;
    endcase
  end

  // Burst FSM: AW capture, beat counting, B response hold
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= c_resp_okay;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          awready_q <= 1'b1;
          if (awvalid && awready_q) begin
            awready_q <= 1'b0;
            id_q      <= awid;
            addr_q    <= awaddr;
            len_q     <= awlen;
            size_q    <= awsize;
            burst_q   <= awburst;
            cnt_q     <= '0;
            err_q     <= w_aw_err;
            state_q   <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_beat) begin
            cnt_q  <= cnt_q + 8'd1;
            addr_q <= addr_d;
            if (w_last_err) begin
              err_q <= 1'b1;
            end
            if (w_last_beat) begin
              state_q  <= S_RESP;
              bvalid_q <= 1'b1;
              bid_q    <= id_q;
              bresp_q  <= (err_q || w_last_err) ? c_resp_slverr : c_resp_okay;
            end
          end
        end
        S_RESP: begin
          if (bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign awready   = awready_q;
  assign wready    = (state_q == S_DATA) && mem_ready;
  assign bvalid    = bvalid_q;
  assign bid       = bid_q;
  assign bresp     = bresp_q;
  assign mem_we    = w_beat && !err_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata;
  assign mem_wstrb = wstrb;

endmodule
`default_nettype wire

// File: tb/tb_axi_wr_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_wr_slave
// Brief    : Directed self-checking bench for axi_wr_slave. Honours
//            WR_SLV_LAST_CHECK_EN when the design is built with it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_wr_slave;

  logic         clk;
  logic         resetn;
  logic         awvalid;
  logic         awready;
  logic [7:0]   awid;
  logic [63:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         wvalid;
  logic         wready;
  logic [511:0] wdata;
  logic [63:0]  wstrb;
  logic         wlast;
  logic         bvalid;
  logic         bready;
  logic [7:0]   bid;
  logic [1:0]   bresp;
  logic         mem_we;
  logic [63:0]  mem_addr;
  logic [511:0] mem_wdata;
  logic [63:0]  mem_wstrb;
  logic         mem_ready;

  int n_cmp;
  int n_bad;

  // observations of the most recent run_burst
  logic [63:0] obs_addr[$];
  int          obs_we;
  int          obs_cycles;
  logic        obs_follow;
  logic        obs_data_ok;
  logic        obs_stable;
  logic        obs_blat;
  logic [1:0]  obs_bresp;
  logic [7:0]  obs_bid;
  logic        obs_aw_after;
  logic        obs_b_after;
  logic        obs_timeout;

  axi_wr_slave #(.ADDR_W(64), .DATA_W(512), .ID_W(8)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .awvalid   (awvalid),
    .awready   (awready),
    .awid      (awid),
    .awaddr    (awaddr),
    .awlen     (awlen),
    .awsize    (awsize),
    .awburst   (awburst),
    .wvalid    (wvalid),
    .wready    (wready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wlast     (wlast),
    .bvalid    (bvalid),
    .bready    (bready),
    .bid       (bid),
    .bresp     (bresp),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one complete burst and record what the DUT did
  task automatic run_burst(input logic [7:0] id, input logic [63:0] addr,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int wlast_idx,
                           input logic [15:0] rdy_pat, input int bdelay);
    int beats;
    int cyc;
    int waitn;
    obs_addr.delete();
    obs_we = 0; obs_cycles = 0; obs_follow = 1'b1; obs_data_ok = 1'b1;
    obs_stable = 1'b1; obs_blat = 1'b0; obs_timeout = 1'b0;
    obs_bresp = 2'bxx; obs_bid = 8'hxx; obs_aw_after = 1'b0; obs_b_after = 1'b1;
    waitn = 0;
    while (awready !== 1'b1 && waitn < 20) begin
      step();
      waitn++;
    end
    if (awready !== 1'b1) begin
      obs_timeout = 1'b1;
      return;
    end
    awvalid = 1'b1; awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
    step();
    awvalid = 1'b0;
    beats = 0;
    cyc = 0;
    while (beats <= int'(len) && cyc < 100) begin
      wvalid    = 1'b1;
      wdata     = {16{32'hA5A5_0000 ^ 32'(cyc)}};
      wstrb     = {2{32'h0F0F_0000 | 32'(cyc)}};
      wlast     = (beats == wlast_idx);
      mem_ready = (cyc < 16) ? rdy_pat[cyc] : 1'b1;
      #1;
      if (wready !== mem_ready) obs_follow = 1'b0;
      if (wready === 1'b1) begin
        obs_addr.push_back(mem_addr);
        if (mem_wdata !== wdata || mem_wstrb !== wstrb) obs_data_ok = 1'b0;
        beats++;
      end
      if (mem_we === 1'b1) obs_we++;
      cyc++;
      step();
    end
    obs_cycles = cyc;
    wvalid = 1'b0; wlast = 1'b0; mem_ready = 1'b1; bready = 1'b0;
    if (beats <= int'(len)) begin
      obs_timeout = 1'b1;
      return;
    end
    #1;
    obs_blat  = bvalid;
    obs_bresp = bresp;
    obs_bid   = bid;
    for (int i = 0; i < bdelay; i++) begin
      step();
      if (bvalid !== 1'b1 || bresp !== obs_bresp || bid !== obs_bid) obs_stable = 1'b0;
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
    obs_aw_after = awready;
    obs_b_after  = bvalid;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) step();
    n_cmp++;
    if ({awready, wready, bvalid, bid, bresp, mem_we, mem_addr} !== 78'd0) begin
      n_bad++;
      $display("FAIL reset_values: got aw=%b w=%b b=%b bid=%h bresp=%b we=%b addr=%h, want all 0",
               awready, wready, bvalid, bid, bresp, mem_we, mem_addr);
    end
    resetn = 1'b1;
    step();
    n_cmp++;
    if (awready !== 1'b1) begin
      n_bad++;
      $display("FAIL awready_after_release: got %b want 1", awready);
    end
  endtask

  task automatic test_incr();
    run_burst(8'h5A, 64'h1000, 8'd3, 3'd6, 2'b01, 3, 16'hFFFF, 0);
    n_cmp++;
    if (obs_timeout || obs_addr.size() != 4 || obs_addr[0] !== 64'h1000 ||
        obs_addr[1] !== 64'h1040 || obs_addr[2] !== 64'h1080 || obs_addr[3] !== 64'h10C0) begin
      n_bad++;
      $display("FAIL incr_addr: got n=%0d first=%h last=%h, want 1000/1040/1080/10C0",
               obs_addr.size(), (obs_addr.size() > 0) ? obs_addr[0] : 64'hx,
               (obs_addr.size() > 3) ? obs_addr[3] : 64'hx);
    end
    n_cmp++;
    if (obs_cycles != 4 || obs_we != 4) begin
      n_bad++;
      $display("FAIL incr_beats: got cycles=%0d we=%0d want 4/4", obs_cycles, obs_we);
    end
    n_cmp++;
    if (obs_blat !== 1'b1 || obs_bresp !== 2'b00 || obs_bid !== 8'h5A) begin
      n_bad++;
      $display("FAIL incr_resp: got bvalid=%b bresp=%b bid=%h want 1/00/5A",
               obs_blat, obs_bresp, obs_bid);
    end
    n_cmp++;
    if (obs_data_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL incr_passthru: got %b want 1", obs_data_ok);
    end
    n_cmp++;
    if (obs_aw_after !== 1'b1 || obs_b_after !== 1'b0) begin
      n_bad++;
      $display("FAIL incr_turnaround: got awready=%b bvalid=%b want 1/0", obs_aw_after, obs_b_after);
    end
  endtask

  task automatic test_wrap();
    run_burst(8'h21, 64'h1030, 8'd3, 3'd4, 2'b10, 3, 16'hFFFF, 0);
    n_cmp++;
    if (obs_timeout || obs_addr.size() != 4 || obs_addr[0] !== 64'h1030 ||
        obs_addr[1] !== 64'h1000 || obs_addr[2] !== 64'h1010 || obs_addr[3] !== 64'h1020) begin
      n_bad++;
      $display("FAIL wrap_addr: got n=%0d second=%h, want 1030/1000/1010/1020",
               obs_addr.size(), (obs_addr.size() > 1) ? obs_addr[1] : 64'hx);
    end
    n_cmp++;
    if (obs_bresp !== 2'b00 || obs_we != 4) begin
      n_bad++;
      $display("FAIL wrap_resp: got bresp=%b we=%0d want 00/4", obs_bresp, obs_we);
    end
  endtask

  task automatic test_fixed_unaligned();
    run_burst(8'h03, 64'h3000, 8'd2, 3'd3, 2'b00, 2, 16'hFFFF, 0);
    n_cmp++;
    if (obs_timeout || obs_addr.size() != 3 || obs_addr[0] !== 64'h3000 ||
        obs_addr[1] !== 64'h3000 || obs_addr[2] !== 64'h3000 || obs_bresp !== 2'b00) begin
      n_bad++;
      $display("FAIL fixed_addr: got n=%0d bresp=%b want 3x3000/00", obs_addr.size(), obs_bresp);
    end
    run_burst(8'h04, 64'h1010, 8'd1, 3'd6, 2'b01, 1, 16'hFFFF, 0);
    n_cmp++;
    if (obs_timeout || obs_addr.size() != 2 || obs_addr[0] !== 64'h1010 || obs_addr[1] !== 64'h1040) begin
      n_bad++;
      $display("FAIL incr_unaligned: got n=%0d second=%h want 1010/1040",
               obs_addr.size(), (obs_addr.size() > 1) ? obs_addr[1] : 64'hx);
    end
  endtask

  task automatic test_errors();
    run_burst(8'h77, 64'h4000, 8'd1, 3'd6, 2'b11, 1, 16'hFFFF, 0);
    n_cmp++;
    if (obs_timeout || obs_addr.size() != 2 || obs_we != 0 || obs_bresp !== 2'b10 || obs_bid !== 8'h77) begin
      n_bad++;
      $display("FAIL err_reserved: got beats=%0d we=%0d bresp=%b bid=%h want 2/0/10/77",
               obs_addr.size(), obs_we, obs_bresp, obs_bid);
    end
    run_burst(8'h78, 64'h1008, 8'd3, 3'd4, 2'b10, 3, 16'hFFFF, 0);
    n_cmp++;
    if (obs_timeout || obs_we != 0 || obs_bresp !== 2'b10) begin
      n_bad++;
      $display("FAIL err_wrap_misalign: got we=%0d bresp=%b want 0/10", obs_we, obs_bresp);
    end
    run_burst(8'h79, 64'h1000, 8'd2, 3'd4, 2'b10, 2, 16'hFFFF, 0);
    n_cmp++;
    if (obs_timeout || obs_addr.size() != 3 || obs_we != 0 || obs_bresp !== 2'b10) begin
      n_bad++;
      $display("FAIL err_wrap_len: got beats=%0d we=%0d bresp=%b want 3/0/10",
               obs_addr.size(), obs_we, obs_bresp);
    end
    run_burst(8'h7A, 64'h1000, 8'd0, 3'd7, 2'b01, 0, 16'hFFFF, 0);
    n_cmp++;
    if (obs_timeout || obs_we != 0 || obs_bresp !== 2'b10) begin
      n_bad++;
      $display("FAIL err_size: got we=%0d bresp=%b want 0/10", obs_we, obs_bresp);
    end
  endtask

  task automatic test_backpressure();
    // mem_ready per data cycle: 1,0,0,1 then 1s
    run_burst(8'h42, 64'h2000, 8'd3, 3'd6, 2'b01, 3, 16'hFFF9, 3);
    n_cmp++;
    if (obs_follow !== 1'b1 || obs_cycles != 6) begin
      n_bad++;
      $display("FAIL bp_wready: got follow=%b cycles=%0d want 1/6", obs_follow, obs_cycles);
    end
    n_cmp++;
    if (obs_timeout || obs_we != 4 || obs_addr.size() != 4 || obs_addr[3] !== 64'h20C0) begin
      n_bad++;
      $display("FAIL bp_writes: got we=%0d n=%0d want 4/4 ending 20C0", obs_we, obs_addr.size());
    end
    n_cmp++;
    if (obs_stable !== 1'b1 || obs_bresp !== 2'b00 || obs_bid !== 8'h42 || obs_b_after !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_bhold: got stable=%b bresp=%b bid=%h bvalid_after=%b want 1/00/42/0",
               obs_stable, obs_bresp, obs_bid, obs_b_after);
    end
  endtask

  task automatic test_last_check();
    run_burst(8'h11, 64'h5000, 8'd3, 3'd6, 2'b01, 1, 16'hFFFF, 0);
`ifdef WR_SLV_LAST_CHECK_EN
    n_cmp++;
    if (obs_timeout || obs_addr.size() != 4 || obs_we != 2 || obs_bresp !== 2'b10) begin
      n_bad++;
      $display("FAIL last_check: got beats=%0d we=%0d bresp=%b want 4/2/10",
               obs_addr.size(), obs_we, obs_bresp);
    end
`else
    n_cmp++;
    if (obs_timeout || obs_addr.size() != 4 || obs_we != 4 || obs_bresp !== 2'b00) begin
      n_bad++;
      $display("FAIL last_ignored: got beats=%0d we=%0d bresp=%b want 4/4/00",
               obs_addr.size(), obs_we, obs_bresp);
    end
`endif
  endtask

  task automatic test_reset_mid_burst();
    int waitn;
    waitn = 0;
    while (awready !== 1'b1 && waitn < 20) begin
      step();
      waitn++;
    end
    awvalid = 1'b1; awid = 8'h99; awaddr = 64'h6000; awlen = 8'd7; awsize = 3'd6; awburst = 2'b01;
    step();
    awvalid = 1'b0;
    wvalid = 1'b1; mem_ready = 1'b1; wlast = 1'b0;
    step();
    resetn = 1'b0;
    step();
    n_cmp++;
    if ({awready, wready, bvalid, bid, bresp, mem_we, mem_addr} !== 78'd0) begin
      n_bad++;
      $display("FAIL midburst_reset: got aw=%b w=%b b=%b bid=%h bresp=%b we=%b addr=%h, want all 0",
               awready, wready, bvalid, bid, bresp, mem_we, mem_addr);
    end
    wvalid = 1'b0;
    step();
    resetn = 1'b1;
    step();
    run_burst(8'h66, 64'h7000, 8'd1, 3'd6, 2'b01, 1, 16'hFFFF, 0);
    n_cmp++;
    if (obs_timeout || obs_we != 2 || obs_bresp !== 2'b00 || obs_bid !== 8'h66 ||
        obs_addr.size() != 2 || obs_addr[1] !== 64'h7040) begin
      n_bad++;
      $display("FAIL after_reset_burst: got we=%0d bresp=%b bid=%h want 2/00/66",
               obs_we, obs_bresp, obs_bid);
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    resetn = 1'b0; awvalid = 1'b0; awid = '0; awaddr = '0; awlen = '0; awsize = '0;
    awburst = '0; wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0; bready = 1'b0;
    mem_ready = 1'b1;
    test_reset();
    test_incr();
    test_wrap();
    test_fixed_unaligned();
    test_errors();
    test_backpressure();
    test_last_check();
    test_reset_mid_burst();
    if (obs_timeout) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: last burst did not complete");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
